// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock, LSB chunk first,
// carrying between chunks in a register. Subtract is a + ~b + ~cin.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
  // in_ready and out_valid come only from registered state, never from inputs.
  state_t state, state_next;

  logic             live;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [KW-1:0]    k;
  logic [CHUNK-1:0] a_c, b_c, s_c;
  logic             c_out, c_msb;
  logic             accept, last;

  assign in_ready  = live && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (k == K_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign a_c = a_q[k*CHUNK +: CHUNK];
  assign b_c = b_q[k*CHUNK +: CHUNK];
  assign {c_out, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
  // Carry into the chunk's top bit, recovered from that bit's sum.
  assign c_msb = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ s_c[CHUNK-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        a_q   <= a;
        b_q   <= sub ? ~b : b;
        carry <= cin ^ sub;
        k     <= '0;
      end else if (state == BUSY) begin
        sum[k*CHUNK +: CHUNK] <= s_c;
        carry <= c_out;
        if (last) begin
          cout <= c_out;
          ovf  <= c_msb ^ c_out;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: directed cases on a 32/8 instance, then random regression
// on four width/chunk configurations against an integer arithmetic model.
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic start_rand = 1'b0;
  logic r_rst = 1'b1;

  // Model result packed as {ovf, cout, sum zero-extended to 32 bits}.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                                         input logic ci, input logic sub_f);
    longint ua, ub, mdl, half, sa, sbv, r, sr, c;
    logic co, ov;
    mdl  = longint'(1) << w;
    half = mdl >> 1;
    ua   = longint'(av) & (mdl - 1);
    ub   = longint'(bv) & (mdl - 1);
    c    = ci ? 1 : 0;
    sa   = (ua >= half) ? ua - mdl : ua;
    sbv  = (ub >= half) ? ub - mdl : ub;
    if (!sub_f) begin
      r  = ua + ub + c;
      co = (r >= mdl);
      sr = sa + sbv + c;
    end else begin
      r  = ua - ub - c;
      co = (ua >= ub + c);
      sr = sa - sbv - c;
    end
    ov = (sr >= half) || (sr < -half);
    return {ov, co, 32'(r & (mdl - 1))};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- directed instance (32/8) ----------------
  logic        d_rst = 1'b1;
  logic        d_in_valid = 1'b0, d_in_ready, d_cin = 1'b0, d_sub = 1'b0;
  logic        d_out_valid, d_out_ready = 1'b0, d_cout, d_ovf;
  logic [31:0] d_a = '0, d_b = '0, d_sum;

  chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
  );

  // Present one operation, return its result and the edges from acceptance to out_valid.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb,
                        output logic [33:0] res, output int lat);
    int g = 0;
    while (!d_in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!d_in_ready) chk("in_ready_timeout", 0, 1);
    d_a = av; d_b = bv; d_cin = ci; d_sub = sb; d_in_valid = 1'b1;
    @(posedge clk);
    #1 d_in_valid = 1'b0;
    lat = 0;
    while (!d_out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
    end
    res = {d_ovf, d_cout, d_sum};
  endtask

  task automatic release_out();
    @(negedge clk);
    d_out_ready = 1'b1;
    @(posedge clk);
    #1 d_out_ready = 1'b0;
  endtask

  // ---------------- random instances ----------------
  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = (g == 3) ? 12 : 32;
    localparam int C = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 32 : 4;
    localparam int N = W / C;
    localparam int N_OPS = 250;

    logic         r_in_valid = 1'b0, r_in_ready, r_cin = 1'b0, r_sub = 1'b0;
    logic         r_out_valid, r_out_ready = 1'b0, r_cout, r_ovf;
    logic [W-1:0] r_a = '0, r_b = '0, r_sum;
    logic [33:0]  exp_q[$];
    int           acc_q[$];
    int           n_acc = 0;
    int           ncyc = 0;
    bit           prev_ov = 1'b0;
    bit           done = 1'b0;

    chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk(clk), .rst(r_rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
      .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub), .out_valid(r_out_valid),
      .out_ready(r_out_ready), .sum(r_sum), .cout(r_cout), .ovf(r_ovf)
    );

    always @(negedge clk) begin : compare
      logic [33:0] got;
      int lat;
      ncyc++;
      if (r_out_valid) begin
        got = {r_ovf, r_cout, 32'(r_sum)};
        if (exp_q.size() == 0) begin
          chk($sformatf("cfg%0d_spurious_valid", g), 1, 0);
        end else begin
          if (!prev_ov) begin
            lat = ncyc - acc_q[0] - 1;
            chk($sformatf("cfg%0d_latency", g), 64'(lat), 64'(N));
          end
          chk($sformatf("cfg%0d_result", g), 64'(got), 64'(exp_q[0]));
          if (r_out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      if (r_in_valid && r_in_ready) begin
        exp_q.push_back(ref_op(W, 32'(r_a), 32'(r_b), r_cin, r_sub));
        acc_q.push_back(ncyc);
        n_acc++;
      end
      prev_ov = r_out_valid;
    end

    initial begin : driver
      int guard = 0;
      wait (start_rand);
      while ((n_acc < N_OPS || exp_q.size() != 0) && guard < 20000) begin
        @(posedge clk);
        #1;
        r_a = W'($urandom());
        r_b = W'($urandom());
        r_cin = 1'($urandom_range(0, 1));
        r_sub = 1'($urandom_range(0, 1));
        r_in_valid = (n_acc < N_OPS) && ($urandom_range(0, 3) != 0);
        r_out_ready = ($urandom_range(0, 2) != 0);
        guard++;
      end
      r_in_valid = 1'b0;
      if (guard >= 20000) chk($sformatf("cfg%0d_drain_timeout", g), 64'(n_acc), 64'(N_OPS));
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [33:0] res, held;
    int lat, g;

    // Model pinned against hand-worked results.
    chk("model_add_wrap", 64'(ref_op(32, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0)), 64'({1'b0, 1'b1, 32'h0}));
    chk("model_add_ovf", 64'(ref_op(32, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0)), 64'({1'b1, 1'b0, 32'h80000000}));
    chk("model_sub_neg", 64'(ref_op(32, 32'd5, 32'd7, 1'b0, 1'b1)), 64'({1'b0, 1'b0, 32'hFFFFFFFE}));
    chk("model_sub_12b", 64'(ref_op(12, 32'h800, 32'h1, 1'b0, 1'b1)), 64'({1'b1, 1'b1, 32'h7FF}));

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(d_in_ready), 0);
    chk("reset_out_valid", 64'(d_out_valid), 0);
    chk("reset_sum", 64'({d_ovf, d_cout, d_sum}), 0);
    d_rst = 1'b0;
    r_rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_reset", 64'(d_in_ready), 1);

    run_op(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, res, lat);
    chk("t1_result", 64'(res), 64'({1'b0, 1'b1, 32'h0}));
    chk("t1_latency", 64'(lat), 4);
    release_out();
    run_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, res, lat);
    chk("t2_result", 64'(res), 64'({1'b1, 1'b0, 32'h80000000}));
    release_out();
    run_op(32'd5, 32'd7, 1'b0, 1'b1, res, lat);
    chk("t3a_result", 64'(res), 64'({1'b0, 1'b0, 32'hFFFFFFFE}));
    release_out();
    run_op(32'h80000000, 32'h1, 1'b0, 1'b1, res, lat);
    chk("t3b_result", 64'(res), 64'({1'b1, 1'b1, 32'h7FFFFFFF}));
    release_out();
    run_op(32'd10, 32'd3, 1'b1, 1'b1, res, lat);
    chk("t3c_sum_cout", 64'(res[32:0]), 64'({1'b1, 32'd6}));
    release_out();

    // Backpressure: stall in DONE while the input side churns.
    run_op(32'h0F0F0F0F, 32'h01010101, 1'b1, 1'b0, res, lat);
    held = {1'b0, 1'b0, 32'h10101011};
    chk("t4_result", 64'(res), 64'(held));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      d_in_valid = ~d_in_valid;
      d_a = $urandom();
      d_b = $urandom();
      d_sub = ~d_sub;
      @(negedge clk);
      chk("t4_hold_valid_ready", 64'({d_out_valid, d_in_ready}), 64'(2'b10));
      chk("t4_hold_outputs", 64'({d_ovf, d_cout, d_sum}), 64'(held));
    end
    d_out_ready = 1'b1;
    @(posedge clk);
    #1;
    d_out_ready = 1'b0;
    d_in_valid = 1'b0;
    chk("t4_idle_after_pulse", 64'({d_out_valid, d_in_ready}), 64'(2'b01));
    repeat (6) @(negedge clk);
    chk("t4_nothing_queued", 64'(d_out_valid), 0);

    // Reset after two of four chunks.
    @(negedge clk);
    d_a = 32'hFFFFFFFF; d_b = 32'hFFFFFFFF; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
    @(posedge clk);
    #1 d_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 d_rst = 1'b1;
    #1;
    chk("t5_reset_out_valid", 64'(d_out_valid), 0);
    chk("t5_reset_outputs", 64'({d_ovf, d_cout, d_sum}), 0);
    chk("t5_reset_in_ready", 64'(d_in_ready), 0);
    repeat (2) @(negedge clk);
    d_rst = 1'b0;
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, res, lat);
    chk("t5_after_reset", 64'(res[32:0]), 64'({1'b0, 32'h23456789}));
    chk("t5_latency", 64'(lat), 4);
    release_out();

    start_rand = 1'b1;
    g = 0;
    while (!(cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done) && g < 60000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 60000) chk("random_timeout", 64'(g), 0);
    chk("random_ops_accepted", 64'(cfg[0].n_acc + cfg[1].n_acc + cfg[2].n_acc + cfg[3].n_acc), 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
